clm_sbox_inv_lanes: RTL and testbench

- Multi-lane sequential inversion core for the CLM masked AES datapath.
- Computes x^254 mod PQ per lane, in the redundant ring GF(2)[x]/(PQ), with deg(PQ) = 8+D. Reduced mod P, the result equals the AES field inverse.
- Successor to the fixed-d, fixed-4-byte S-box stage sequence:
  - redundancy D, lane count LANES and the square-count schedule are generic;
  - adds a busy indicator, per-op capture of PQ/P, and optional per-multiply randomness refresh.
- Sits in front of the S-box affine stage inside SUB_BYTES and sub_word of the key schedule.

---
 rtl/clm_sbox_inv_lanes.sv | 183 ++++++++++++++++++
 tb/tb_clm_sbox_inv_lanes.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clm_sbox_inv_lanes.sv
// Multi-lane x^254 inversion core over GF(2)[x]/(PQ), with deg(PQ) = 8+D.
// Build option CLM_SBOX_REFRESH_EN adds an r_lane*P re-mask after every multiply.
module clm_sbox_inv_lanes #(
  parameter int D     = 4,
  parameter int LANES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      drdy_i,
  input  logic [LANES*(8+D)-1:0]    in,
  input  logic [8+D:0]              pq,
  input  logic [8:0]                p,
  input  logic [LANES*D-1:0]        r,
  output logic [LANES*(8+D)-1:0]    out,
  output logic                      drdy_o,
  output logic                      busy
);

  localparam int W = 8 + D;

  // state | meaning
  // IDLE  | waiting for drdy_i; out holds the last result
  // SQ1   | acc = x^2, copy kept in r2
  // MUL_A | acc = x^3, copy kept in base
  // SQ4   | two squarings -> x^12, copy kept in r12 on the second
  // MUL_B | acc = x^15
  // SQ16  | four squarings -> x^240
  // MUL_C | acc = x^252
  // MUL_D | acc = x^254, result published, drdy_o next cycle
  typedef enum logic [2:0] {IDLE, SQ1, MUL_A, SQ4, MUL_B, SQ16, MUL_C, MUL_D} state_t;

  state_t     state, state_next;
  logic [1:0] sq_cnt, sq_cnt_next;

  logic [W-1:0] acc  [LANES];
  logic [W-1:0] base [LANES];
  logic [W-1:0] r2   [LANES];
  logic [W-1:0] r12  [LANES];
  logic [W-1:0] opb  [LANES];
  logic [W-1:0] mul_res [LANES];
  logic [LANES*W-1:0] res_flat;
  logic [W:0]   pq_q;
  logic [8:0]   p_q;
  logic         drdy_q;
  logic [LANES*W-1:0] out_q;

  // Carry-less product reduced modulo m; the reduction walks every bit from
  // degree 2W-2 down to W, so any full-width product is handled.
  function automatic logic [W-1:0] clmul_mod(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W:0]   m);
    logic [2*W-2:0] prod;
    prod = '0;
    for (int i = 0; i < W; i++)
      if (b[i]) prod = prod ^ ({{(W-1){1'b0}}, a} << i);
    for (int k = 2*W-2; k >= W; k--)
      if (prod[k]) prod = prod ^ ({{(W-2){1'b0}}, m} << (k-W));
    return prod[W-1:0];
  endfunction

`ifdef CLM_SBOX_REFRESH_EN
  // D-bit by 9-bit carry-less product is exactly W bits: no reduction needed.
  function automatic logic [W-1:0] clmul_rp(input logic [D-1:0] rl,
                                            input logic [8:0]   pp);
    logic [W-1:0] acc_rp;
    acc_rp = '0;
    for (int i = 0; i < D; i++)
      if (rl[i]) acc_rp = acc_rp ^ ({{(D-1){1'b0}}, pp} << i);
    return acc_rp;
  endfunction

  logic is_mul;
  assign is_mul = (state == MUL_A) || (state == MUL_B) ||
                  (state == MUL_C) || (state == MUL_D);
`else
  logic unused_refresh;
  assign unused_refresh = ^{r, p_q};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sq_cnt <= 2'd0;
    end else begin
      state  <= state_next;
      sq_cnt <= sq_cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    sq_cnt_next = sq_cnt;
    case (state)
      IDLE:  if (drdy_i) begin
               state_next  = SQ1;
               sq_cnt_next = 2'd0;
             end
      SQ1:   state_next = MUL_A;
      MUL_A: begin
               state_next  = SQ4;
               sq_cnt_next = 2'd0;
             end
      SQ4:   if (sq_cnt == 2'd1) state_next = MUL_B;
             else sq_cnt_next = sq_cnt + 2'd1;
      MUL_B: begin
               state_next  = SQ16;
               sq_cnt_next = 2'd0;
             end
      SQ16:  if (sq_cnt == 2'd3) state_next = MUL_C;
             else sq_cnt_next = sq_cnt + 2'd1;
      MUL_C: state_next = MUL_D;
      MUL_D: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    res_flat = '0;
    for (int l = 0; l < LANES; l++) begin
      opb[l] = acc[l];
      case (state)
        MUL_A, MUL_B: opb[l] = base[l];
        MUL_C:        opb[l] = r12[l];
        MUL_D:        opb[l] = r2[l];
        default:      opb[l] = acc[l];
      endcase
      mul_res[l] = clmul_mod(acc[l], opb[l], pq_q);
`ifdef CLM_SBOX_REFRESH_EN
      if (is_mul) mul_res[l] = mul_res[l] ^ clmul_rp(r[(LANES-1-l)*D +: D], p_q);
`endif
      res_flat[(LANES-1-l)*W +: W] = mul_res[l];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) begin
        acc[l]  <= '0;
        base[l] <= '0;
        r2[l]   <= '0;
        r12[l]  <= '0;
      end
      pq_q   <= '0;
      p_q    <= '0;
      out_q  <= '0;
      drdy_q <= 1'b0;
    end else begin
      drdy_q <= (state == MUL_D);
      case (state)
        IDLE: if (drdy_i) begin
          for (int l = 0; l < LANES; l++) begin
            acc[l]  <= in[(LANES-1-l)*W +: W];
            base[l] <= in[(LANES-1-l)*W +: W];
          end
          pq_q <= pq;
          p_q  <= p;
        end
        SQ1: for (int l = 0; l < LANES; l++) begin
          acc[l] <= mul_res[l];
          r2[l]  <= mul_res[l];
        end
        MUL_A: for (int l = 0; l < LANES; l++) begin
          acc[l]  <= mul_res[l];
          base[l] <= mul_res[l];
        end
        SQ4: for (int l = 0; l < LANES; l++) begin
          acc[l] <= mul_res[l];
          if (sq_cnt == 2'd1) r12[l] <= mul_res[l];
        end
        MUL_D: begin
          for (int l = 0; l < LANES; l++) acc[l] <= mul_res[l];
          out_q <= res_flat;
        end
        default: for (int l = 0; l < LANES; l++) acc[l] <= mul_res[l];
      endcase
    end
  end

  assign out    = out_q;
  assign drdy_o = drdy_q;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_clm_sbox_inv_lanes.sv
// Scoreboard bench for clm_sbox_inv_lanes: results are checked modulo P against
// hand-computed AES inverses, plus latency, busy, back-to-back and reset behaviour.
module tb_clm_sbox_inv_lanes;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drdy_i = 1'b0;
  logic [47:0] din = '0;
  logic [12:0] pq = 13'h129D;
  logic [8:0]  p = 9'h11B;
  logic [15:0] r = '0;
  logic [47:0] dout;
  logic        drdy_o, busy;

  logic        drdy2 = 1'b0;
  logic [9:0]  din2 = '0;
  logic [10:0] pq2 = 11'h741;  // P * (x^2+x+1)
  logic [1:0]  r2 = '0;
  logic [9:0]  dout2;
  logic        drdy_o2, busy2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0][7:0]  modp;
    logic [3:0][11:0] raw;
    logic [3:0]       raw_chk;
    int               start;
  } exp_t;
  exp_t exp_q[$];

  clm_sbox_inv_lanes #(.D(4), .LANES(4)) dut (
    .clk(clk), .rst(rst), .drdy_i(drdy_i), .in(din), .pq(pq), .p(p), .r(r),
    .out(dout), .drdy_o(drdy_o), .busy(busy));

  clm_sbox_inv_lanes #(.D(2), .LANES(1)) dut2 (
    .clk(clk), .rst(rst), .drdy_i(drdy2), .in(din2), .pq(pq2), .p(p), .r(r2),
    .out(dout2), .drdy_o(drdy_o2), .busy(busy2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    r  = 16'($urandom);
    r2 = 2'($urandom);
  end

  function automatic logic [7:0] mod_p(input logic [11:0] v);
    logic [15:0] t;
    t = {4'b0, v};
    for (int k = 15; k >= 8; k--)
      if (t[k]) t = t ^ (16'h011B << (k-8));
    return t[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every drdy_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && drdy_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_drdy_o: got pulse expected none (t=%0t)", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("latency", cyc - e.start, 11);
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("lane%0d_modp", i), mod_p(dout[(3-i)*12 +: 12]), e.modp[i]);
          if (e.raw_chk[i]) chk($sformatf("lane%0d_raw", i), dout[(3-i)*12 +: 12], e.raw[i]);
        end
      end
    end
  end

  task automatic push_exp(input logic [11:0] l0, l1, l2, l3,
                          input logic [7:0]  e0, e1, e2, e3);
    exp_t e;
    logic [3:0][11:0] ls;
    ls = {l3, l2, l1, l0};
    e.modp = {e3, e2, e1, e0};
    e.raw  = ls;
    for (int i = 0; i < 4; i++) begin
`ifdef CLM_SBOX_REFRESH_EN
      e.raw_chk[i] = 1'b0;
`else
      e.raw_chk[i] = (ls[i] <= 12'd1);  // 0 and 1 are their own canonical inverses
`endif
    end
    e.start = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Drives at a negedge; returns at the negedge after the accepting edge E0.
  task automatic launch(input logic [11:0] l0, l1, l2, l3,
                        input logic [7:0]  e0, e1, e2, e3);
    @(negedge clk);
    din = {l0, l1, l2, l3};
    drdy_i = 1'b1;
    push_exp(l0, l1, l2, l3, e0, e1, e2, e3);
    @(negedge clk);
    drdy_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 80) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int hi;
    int st;
    bit seen;

    repeat (3) @(negedge clk);
    chk("reset_out", dout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_drdy_o", drdy_o, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic lanes and busy window
    launch(12'h000, 12'h001, 12'h002, 12'h053, 8'h00, 8'h01, 8'h8D, 8'hCA);
    hi = 0;
    for (int i = 0; i < 11; i++) begin
      if (busy) hi++;
      @(negedge clk);
    end
    chk("busy_cycles", hi, 11);
    chk("busy_low_after", busy, 0);
    wait_drain("t1");

    // Masked operands (x + k*P) still invert to the same residue
    launch(12'h524, 12'h32C, 12'h08D, 12'h0CA, 8'hCA, 8'h01, 8'h02, 8'h53);
    wait_drain("t2a");
    launch(12'h003, 12'h0F6, 12'h524, 12'h000, 8'hF6, 8'h03, 8'hCA, 8'h00);
    wait_drain("t2b");

    // drdy_i held high: each accept takes fresh lanes
    for (int k = 0; k < 3; k++) begin
      hi = 0;
      while (busy && hi < 20) begin
        @(negedge clk);
        hi++;
      end
      case (k)
        0: begin din = {12'h002, 12'h003, 12'h053, 12'h001};
                 push_exp(12'h002, 12'h003, 12'h053, 12'h001, 8'h8D, 8'hF6, 8'hCA, 8'h01); end
        1: begin din = {12'h0CA, 12'h08D, 12'h000, 12'h524};
                 push_exp(12'h0CA, 12'h08D, 12'h000, 12'h524, 8'h53, 8'h02, 8'h00, 8'hCA); end
        default: begin din = {12'h32C, 12'h0F6, 12'h002, 12'h003};
                 push_exp(12'h32C, 12'h0F6, 12'h002, 12'h003, 8'h01, 8'h03, 8'h8D, 8'hF6); end
      endcase
      drdy_i = 1'b1;
      @(negedge clk);
    end
    drdy_i = 1'b0;
    wait_drain("t3");

    // Second strobe mid-op ignored; pq change after capture has no effect
    launch(12'h002, 12'h053, 12'h001, 12'h003, 8'h8D, 8'hCA, 8'h01, 8'hF6);
    pq  = 13'h1FFF;
    din = {12'h0CA, 12'h0CA, 12'h0CA, 12'h0CA};
    repeat (4) @(negedge clk);
    drdy_i = 1'b1;
    @(negedge clk);
    drdy_i = 1'b0;
    pq = 13'h129D;
    wait_drain("t4");
    repeat (15) @(negedge clk);

    // Asynchronous reset mid-op
    @(negedge clk);
    din = {12'h002, 12'h002, 12'h002, 12'h002};
    drdy_i = 1'b1;
    @(negedge clk);
    drdy_i = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_out", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drdy_o", drdy_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    launch(12'h053, 12'h000, 12'h003, 12'h002, 8'hCA, 8'h00, 8'hF6, 8'h8D);
    wait_drain("t5");

    // Narrow single-lane build
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      din2 = (v == 0) ? 10'h002 : 10'h053;
      drdy2 = 1'b1;
      st = cyc + 1;
      @(negedge clk);
      drdy2 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (drdy_o2) seen = 1'b1;
        else @(negedge clk);
      end
      if (!seen) begin
        n_cmp++;
        n_bad++;
        $display("FAIL t6_timeout: got no drdy_o expected pulse");
      end else begin
        chk("t6_latency", cyc - st, 11);
        chk("t6_modp", mod_p({2'b0, dout2}), (v == 0) ? 8'h8D : 8'hCA);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
